// File: rtl/sum_ascii_tx.sv
// Sends a 5-bit sum to a byte UART as two ASCII decimal digits, optionally followed by CR LF.
// Each byte uses a busy handshake. If the UART never acknowledges a byte, the frame aborts and a sticky error is set.
module sum_ascii_tx #(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter bit          SEND_CRLF   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] sum,
    input  logic       uart_busy,
    output logic       uart_tx_en,
    output logic [7:0] uart_tx_data,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [1:0]  LAST_IDX = SEND_CRLF ? 2'd3 : 2'd1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SEND  = 3'd2,
        ACK   = 3'd3,
        DRAIN = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         sum_q, sum_d;
    logic               tx_en_q, tx_en_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    // Byte idx of the frame for captured sum s: tens digit, units digit, CR, LF
    function automatic logic [7:0] frame_byte(input logic [4:0] s, input logic [1:0] idx);
        logic [1:0] tens;
        logic [4:0] units;
        if (s >= 5'd30)      tens = 2'd3;
        else if (s >= 5'd20) tens = 2'd2;
        else if (s >= 5'd10) tens = 2'd1;
        else                 tens = 2'd0;
        units = s - (5'(tens) * 5'd10);
        case (idx)
            2'd0:    frame_byte = 8'h30 + 8'(tens);
            2'd1:    frame_byte = 8'h30 + 8'(units);
            2'd2:    frame_byte = 8'h0D;
            default: frame_byte = 8'h0A;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        tx_en_d = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                // busy_q is still high for one cycle after a frame ends, which blocks a start in that cycle
                if (start && !busy_q) begin
                    sum_d   = sum;
                    err_d   = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                idx_d   = 2'd0;
                state_d = SEND;
            end
            SEND: begin
                if (!uart_busy) begin
                    tx_en_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (uart_busy) begin
                    state_d = DRAIN;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (!uart_busy) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d    = (state_d != IDLE) || (state_q != IDLE);
        tx_data_d = (state_d inside {SEND, ACK, DRAIN}) ? frame_byte(sum_d, idx_d) : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign uart_tx_en   = tx_en_q;
    assign uart_tx_data = tx_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_sum_ascii_tx.sv
// Scoreboard bench for sum_ascii_tx: a CR/LF instance and a digits-only instance, each driven by a simple UART busy model.
module tb_sum_ascii_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [4:0] sum_a = '0, sum_b = '0;
    logic       ub_a = 1'b0, ub_b = 1'b0;
    logic       en_a, en_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
    logic [7:0] data_a, data_b;

    sum_ascii_tx #(.ACK_TIMEOUT(16), .SEND_CRLF(1'b1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .sum(sum_a), .uart_busy(ub_a),
        .uart_tx_en(en_a), .uart_tx_data(data_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    sum_ascii_tx #(.ACK_TIMEOUT(16), .SEND_CRLF(1'b0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .sum(sum_b), .uart_busy(ub_b),
        .uart_tx_en(en_b), .uart_tx_data(data_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] exp_a, exp_b;
    int done_cnt_a = 0, done_cnt_b = 0, en_cnt_a = 0, en_cnt_b = 0;
    bit stuck_a = 1'b0;
    int bc_a = 0, bc_b = 0;
    logic prev_en_a = 1'b0, prev_en_b = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // UART model: busy rises the cycle after an accepted strobe and stays high for 10 cycles
    always @(posedge clk) begin
        if (reset) begin
            ub_a <= 1'b0; bc_a <= 0;
        end else if (en_a && !stuck_a) begin
            ub_a <= 1'b1; bc_a <= 10;
        end else if (bc_a > 0) begin
            bc_a <= bc_a - 1;
            if (bc_a == 1) ub_a <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            ub_b <= 1'b0; bc_b <= 0;
        end else if (en_b) begin
            ub_b <= 1'b1; bc_b <= 10;
        end else if (bc_b > 0) begin
            bc_b <= bc_b - 1;
            if (bc_b == 1) ub_b <= 1'b0;
        end
    end

    // Monitors: pop and compare on every strobe, also check the strobe protocol
    always @(negedge clk) begin
        if (!reset) begin
            if (en_a) begin
                en_cnt_a++;
                check("a_en_while_uart_busy", 32'(ub_a), 32'd0);
                check("a_en_back_to_back", 32'(prev_en_a), 32'd0);
                if (qa.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL a_unexpected_byte actual=0x%0h expected=none", data_a);
                end else begin
                    exp_a = qa.pop_front();
                    check("a_byte", 32'(data_a), 32'(exp_a));
                end
            end
            if (done_a) done_cnt_a++;
            prev_en_a = en_a;
        end else begin
            prev_en_a = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (en_b) begin
                en_cnt_b++;
                check("b_en_while_uart_busy", 32'(ub_b), 32'd0);
                check("b_en_back_to_back", 32'(prev_en_b), 32'd0);
                if (qb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b_unexpected_byte actual=0x%0h expected=none", data_b);
                end else begin
                    exp_b = qb.pop_front();
                    check("b_byte", 32'(data_b), 32'(exp_b));
                end
            end
            if (done_b) done_cnt_b++;
            prev_en_b = en_b;
        end else begin
            prev_en_b = 1'b0;
        end
    end

    task automatic wait_done_a(input string name);
        int n = 0;
        while (!done_a && n < 400) begin cyc(); n++; end
        check({name, "_done_seen"}, 32'(done_a), 32'd1);
    endtask

    task automatic wait_idle_a(input string name);
        int n = 0;
        while (busy_a && n < 400) begin cyc(); n++; end
        check({name, "_idle"}, 32'(busy_a), 32'd0);
    endtask

    task automatic finish_frame_a(input string name, input int d0);
        wait_done_a(name);
        cyc();
        check({name, "_done_count"}, 32'(done_cnt_a), 32'(d0 + 1));
        check({name, "_err"}, 32'(err_a), 32'd0);
        check({name, "_queue_empty"}, 32'(qa.size()), 32'd0);
        wait_idle_a(name);
    endtask

    task automatic run_frame_a(input string name, input logic [4:0] s, input logic [7:0] t, input logic [7:0] u);
        int d0;
        d0 = done_cnt_a;
        qa.push_back(t); qa.push_back(u); qa.push_back(8'h0D); qa.push_back(8'h0A);
        sum_a = s; start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        finish_frame_a(name, d0);
    endtask

    typedef struct {
        logic [4:0] s;
        logic [7:0] t;
        logic [7:0] u;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int d0, e0, n;

        vecs[0] = '{5'd31, 8'h33, 8'h31};
        vecs[1] = '{5'd0,  8'h30, 8'h30};
        vecs[2] = '{5'd10, 8'h31, 8'h30};
        vecs[3] = '{5'd19, 8'h31, 8'h39};
        vecs[4] = '{5'd20, 8'h32, 8'h30};
        vecs[5] = '{5'd29, 8'h32, 8'h39};
        vecs[6] = '{5'd30, 8'h33, 8'h30};

        repeat (3) cyc();
        check("rst_en", 32'(en_a), 32'd0);
        check("rst_data", 32'(data_a), 32'h00);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        reset = 1'b0;
        cyc();

        // sum 7 with start-to-strobe latency
        d0 = done_cnt_a;
        qa.push_back(8'h30); qa.push_back(8'h37); qa.push_back(8'h0D); qa.push_back(8'h0A);
        sum_a = 5'd7; start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        check("s7_busy_rise", 32'(busy_a), 32'd1);
        check("s7_load_no_en", 32'(en_a), 32'd0);
        cyc();
        check("s7_send_no_en", 32'(en_a), 32'd0);
        check("s7_send_data", 32'(data_a), 32'h30);
        cyc();
        check("s7_first_en", 32'(en_a), 32'd1);
        finish_frame_a("s7", d0);
        check("s7_idle_data", 32'(data_a), 32'h00);

        for (int i = 0; i < 7; i++) begin
            run_frame_a($sformatf("sum%0d", vecs[i].s), vecs[i].s, vecs[i].t, vecs[i].u);
        end

        // UART never acknowledges: abort after 16 ACK cycles
        d0 = done_cnt_a;
        e0 = en_cnt_a;
        stuck_a = 1'b1;
        qa.push_back(8'h30);
        sum_a = 5'd5; start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        repeat (17) cyc();
        check("to_err_before", 32'(err_a), 32'd0);
        cyc();
        check("to_err_set", 32'(err_a), 32'd1);
        check("to_no_done", 32'(done_a), 32'd0);
        wait_idle_a("to");
        repeat (20) cyc();
        check("to_err_sticky", 32'(err_a), 32'd1);
        check("to_done_count", 32'(done_cnt_a), 32'(d0));
        check("to_en_count", 32'(en_cnt_a), 32'(e0 + 1));
        check("to_queue_empty", 32'(qa.size()), 32'd0);
        stuck_a = 1'b0;

        // Next start clears err; later starts and sum changes are ignored
        d0 = done_cnt_a;
        qa.push_back(8'h31); qa.push_back(8'h32); qa.push_back(8'h0D); qa.push_back(8'h0A);
        sum_a = 5'd12; start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        check("ig_err_cleared", 32'(err_a), 32'd0);
        sum_a = 5'd25;
        start_a = 1'b1; cyc(); start_a = 1'b0;
        repeat (5) cyc();
        start_a = 1'b1; cyc(); start_a = 1'b0;
        wait_done_a("ig");
        check("ig_busy_at_done", 32'(busy_a), 32'd1);
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        check("ig_done_count", 32'(done_cnt_a), 32'(d0 + 1));
        repeat (3) cyc();
        check("ig_start_at_done_ignored", 32'(busy_a), 32'd0);
        check("ig_queue_empty", 32'(qa.size()), 32'd0);

        // Digits-only instance
        qb.push_back(8'h32); qb.push_back(8'h33);
        sum_b = 5'd23; start_b = 1'b1;
        cyc();
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 400) begin cyc(); n++; end
        check("b_done_seen", 32'(done_b), 32'd1);
        cyc();
        check("b_done_count", 32'(done_cnt_b), 32'd1);
        check("b_en_count", 32'(en_cnt_b), 32'd2);
        check("b_queue_empty", 32'(qb.size()), 32'd0);

        // Reset while draining the second byte
        d0 = done_cnt_a;
        e0 = en_cnt_a;
        qa.push_back(8'h31); qa.push_back(8'h35); qa.push_back(8'h0D); qa.push_back(8'h0A);
        sum_a = 5'd15; start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        n = 0;
        while (en_cnt_a < e0 + 2 && n < 400) begin cyc(); n++; end
        check("rd_second_en_seen", 32'(en_cnt_a), 32'(e0 + 2));
        cyc();
        check("rd_drain_data", 32'(data_a), 32'h35);
        reset = 1'b1;
        cyc();
        check("rd_en", 32'(en_a), 32'd0);
        check("rd_data", 32'(data_a), 32'h00);
        check("rd_busy", 32'(busy_a), 32'd0);
        check("rd_done", 32'(done_a), 32'd0);
        reset = 1'b0;
        qa.delete();
        repeat (30) cyc();
        check("rd_no_more_en", 32'(en_cnt_a), 32'(e0 + 2));
        check("rd_no_done", 32'(done_cnt_a), 32'(d0));
        check("rd_still_idle", 32'(busy_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
